ray_scheduler: RTL and testbench

RAY_SCHEDULER -- requirements
Module: ray_scheduler

---
 rtl/rtcore_sched_pkg.sv | 18 +
 rtl/ray_scheduler_if.sv | 47 ++++
 rtl/sched_order_fifo.sv | 62 ++++++
 rtl/ray_scheduler.sv | 159 +++++++++++++++
 tb/tb_ray_scheduler.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtcore_sched_pkg.sv
// Shared types for the ray scheduler: ray/result word widths, lane index type
// and the dispatch FSM state encoding.
package rtcore_sched_pkg;

    localparam int RAY_W     = 256;
    localparam int RESULT_W  = 97;
    localparam int MAX_LANES = 8;

    typedef logic [RAY_W-1:0]              ray_t;
    typedef logic [RESULT_W-1:0]           result_t;
    typedef logic [$clog2(MAX_LANES)-1:0]  lane_id_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } disp_state_e;

endpackage

// File: rtl/ray_scheduler_if.sv
// FIFO-style handshake bundle between the ray scheduler and its upstream ray
// FIFO, the traversal lanes and the downstream result FIFO.
interface ray_scheduler_if #(
    parameter int NUM_LANES = 2
);
    import rtcore_sched_pkg::*;

    logic                            ray_stream_empty_n;
    ray_t                            ray_stream_rd_data;
    logic                            ray_stream_rd_en;

    logic [NUM_LANES-1:0]            lane_ray_full_n;
    ray_t                            lane_ray_wr_data;
    logic [NUM_LANES-1:0]            lane_ray_wr_en;

    logic [NUM_LANES-1:0]            lane_result_empty_n;
    logic [RESULT_W*NUM_LANES-1:0]   lane_result_rd_data;
    logic [NUM_LANES-1:0]            lane_result_rd_en;

    logic                            result_stream_full_n;
    result_t                         result_stream_wr_data;
    logic                            result_stream_wr_en;

    // master is the scheduler; slave is the surrounding FIFO/lane fabric
    modport master (
        input  ray_stream_empty_n, ray_stream_rd_data,
        output ray_stream_rd_en,
        input  lane_ray_full_n,
        output lane_ray_wr_data, lane_ray_wr_en,
        input  lane_result_empty_n, lane_result_rd_data,
        output lane_result_rd_en,
        input  result_stream_full_n,
        output result_stream_wr_data, result_stream_wr_en
    );

    modport slave (
        output ray_stream_empty_n, ray_stream_rd_data,
        input  ray_stream_rd_en,
        output lane_ray_full_n,
        input  lane_ray_wr_data, lane_ray_wr_en,
        output lane_result_empty_n, lane_result_rd_data,
        input  lane_result_rd_en,
        output result_stream_full_n,
        input  result_stream_wr_data, result_stream_wr_en
    );

endinterface

// File: rtl/sched_order_fifo.sv
// Dispatch-order queue: remembers which lane each in-flight ray went to so
// results can be collected in dispatch order. DEPTH must be a power of 2.
module sched_order_fifo
    import rtcore_sched_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic           push,
    input  lane_id_t       push_id,
    input  logic           pop,
    output lane_id_t       head_id,
    output logic [PTR_W:0] count,
    output logic           empty,
    output logic           full
);

    lane_id_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr_q] <= push_id;
    end

    assign head_id = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/ray_scheduler.sv
// Ray scheduler: round-robin dispatch of rays to lanes, in-order result collection.
// Optional statistics counters are built when RAY_SCHEDULER_STATS_EN is defined.
module ray_scheduler
    import rtcore_sched_pkg::*;
#(
    parameter int NUM_LANES   = 2,
    parameter int ORDER_DEPTH = 16
) (
    input  logic            aclk,
    input  logic            aresetn,
    ray_scheduler_if.master bus,
    output logic            busy,
    output logic [31:0]     stat_rays,
    output logic [31:0]     stat_results,
    output logic [31:0]     stat_stalls
);

    localparam int CNT_W = $clog2(ORDER_DEPTH) + 1;

    disp_state_e state_q, state_d;
    ray_t        hold_q, hold_d;
    lane_id_t    rr_ptr_q, rr_ptr_d;
    logic        grant;
    lane_id_t    grant_lane;
    logic        collect;
    logic        head_ready;
    lane_id_t    head_lane;
    logic        q_empty, q_full;
    logic [CNT_W-1:0] q_count;

    // Rotating search: lanes at or above rr_ptr first, then wrap to the lowest ready lane.
    always_comb begin
        grant      = 1'b0;
        grant_lane = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!grant && lane_id_t'(i) >= rr_ptr_q && bus.lane_ray_full_n[i]) begin
                grant      = 1'b1;
                grant_lane = lane_id_t'(i);
            end
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!grant && bus.lane_ray_full_n[i]) begin
                grant      = 1'b1;
                grant_lane = lane_id_t'(i);
            end
        end
        if (state_q != ST_HELD || q_full) grant = 1'b0;

        bus.lane_ray_wr_en = '0;
        for (int i = 0; i < NUM_LANES; i++)
            bus.lane_ray_wr_en[i] = grant && (grant_lane == lane_id_t'(i));

        rr_ptr_d = rr_ptr_q;
        if (grant)
            rr_ptr_d = (grant_lane == lane_id_t'(NUM_LANES-1)) ? '0 : grant_lane + 1'b1;
    end

    always_comb begin
        state_d              = state_q;
        hold_d               = hold_q;
        bus.ray_stream_rd_en = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                bus.ray_stream_rd_en = bus.ray_stream_empty_n;
                if (bus.ray_stream_empty_n) begin
                    hold_d  = bus.ray_stream_rd_data;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                // Refill the hold register in the same cycle it drains.
                if (grant) begin
                    bus.ray_stream_rd_en = bus.ray_stream_empty_n;
                    if (bus.ray_stream_empty_n) hold_d = bus.ray_stream_rd_data;
                    else                        state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_EMPTY;
            hold_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.lane_ray_wr_data = hold_q;

    sched_order_fifo #(.DEPTH(ORDER_DEPTH)) u_order_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (grant),
        .push_id (grant_lane),
        .pop     (collect),
        .head_id (head_lane),
        .count   (q_count),
        .empty   (q_empty),
        .full    (q_full)
    );

    // Only the lane holding the oldest in-flight ray may deliver a result.
    always_comb begin
        head_ready                = 1'b0;
        bus.result_stream_wr_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (head_lane == lane_id_t'(i)) begin
                head_ready                = bus.lane_result_empty_n[i];
                bus.result_stream_wr_data = bus.lane_result_rd_data[RESULT_W*i +: RESULT_W];
            end
        end
        collect                 = !q_empty && head_ready && bus.result_stream_full_n;
        bus.result_stream_wr_en = collect;
        bus.lane_result_rd_en   = '0;
        for (int i = 0; i < NUM_LANES; i++)
            bus.lane_result_rd_en[i] = collect && (head_lane == lane_id_t'(i));
    end

    assign busy = (state_q == ST_HELD) || (q_count != '0);

`ifdef RAY_SCHEDULER_STATS_EN
    logic [31:0] stat_rays_q, stat_rays_d;
    logic [31:0] stat_results_q, stat_results_d;
    logic [31:0] stat_stalls_q, stat_stalls_d;

    always_comb begin
        stat_rays_d    = stat_rays_q    + {31'd0, grant};
        stat_results_d = stat_results_q + {31'd0, collect};
        stat_stalls_d  = stat_stalls_q  + {31'd0, (state_q == ST_HELD) && !grant};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_rays_q    <= '0;
            stat_results_q <= '0;
            stat_stalls_q  <= '0;
        end else begin
            stat_rays_q    <= stat_rays_d;
            stat_results_q <= stat_results_d;
            stat_stalls_q  <= stat_stalls_d;
        end
    end

    assign stat_rays    = stat_rays_q;
    assign stat_results = stat_results_q;
    assign stat_stalls  = stat_stalls_q;
`else
    assign stat_rays    = '0;
    assign stat_results = '0;
    assign stat_stalls  = '0;
`endif

endmodule

// File: tb/tb_ray_scheduler.sv
// Scoreboard bench for ray_scheduler: queue-based FIFO/lane models around the DUT,
// expected results queued in ray issue order and checked by a separate monitor.
`timescale 1ns/1ps
module tb_ray_scheduler;
    import rtcore_sched_pkg::*;

    localparam int NL       = 2;
    localparam int DEPTH    = 16;
    localparam int LANE_CAP = 16;
`ifdef RAY_SCHEDULER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        busy;
    logic [31:0] stat_rays, stat_results, stat_stalls;

    ray_scheduler_if #(.NUM_LANES(NL)) bus ();

    ray_scheduler #(.NUM_LANES(NL), .ORDER_DEPTH(DEPTH)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .bus          (bus.master),
        .busy         (busy),
        .stat_rays    (stat_rays),
        .stat_results (stat_results),
        .stat_stalls  (stat_stalls)
    );

    always #5 aclk = ~aclk;

    int      n_vec = 0;
    int      n_miss = 0;
    int      cycle = 0;
    int      seq = 0;
    int      rays_sent = 0;
    int      n_results = 0;
    int      lane_rd_cnt [NL];
    ray_t    up_q [$];
    result_t exp_q [$];
    ray_t    lane_in_q [NL][$];
    result_t lane_out_q [NL][$];
    int      disp_lane_log [$];
    int      disp_cyc_log [$];
    int      read_cyc_log [$];
    int      pop_cyc_log [$];

    bit          up_en = 1'b0;
    bit          rnd = 1'b0;
    bit          ds_block = 1'b0;
    logic [NL-1:0] lane_block = '0;
    logic [NL-1:0] lane_res_block = '0;

    // The "work" a lane does: any fixed function of the ray that differs per ray.
    function automatic result_t ray_result(ray_t r);
        return r[96:0] ^ r[255:159];
    endfunction

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic send_ray();
        ray_t r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
        r[31:0] = seq;
        seq++;
        up_q.push_back(r);
        exp_q.push_back(ray_result(r));
        rays_sent++;
    endtask

    task automatic drive_inputs();
        bus.ray_stream_empty_n = up_en && (up_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
        bus.ray_stream_rd_data = (up_q.size() > 0) ? up_q[0] : '0;
        for (int i = 0; i < NL; i++) begin
            bus.lane_ray_full_n[i] = !lane_block[i] && (lane_in_q[i].size() < LANE_CAP) &&
                                     (!rnd || $urandom_range(0, 3) != 0);
            bus.lane_result_empty_n[i] = !lane_res_block[i] && (lane_out_q[i].size() > 0) &&
                                         (!rnd || $urandom_range(0, 3) != 0);
            bus.lane_result_rd_data[RESULT_W*i +: RESULT_W] =
                (lane_out_q[i].size() > 0) ? lane_out_q[i][0] : '0;
        end
        bus.result_stream_full_n = !ds_block && (!rnd || $urandom_range(0, 3) != 0);
    endtask

    // Environment: FIFO and lane models; transfers are observed mid-cycle, inputs change after the edge.
    initial begin
        for (int i = 0; i < NL; i++) lane_rd_cnt[i] = 0;
        drive_inputs();
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (bus.ray_stream_rd_en && bus.ray_stream_empty_n) begin
                    void'(up_q.pop_front());
                    read_cyc_log.push_back(cycle);
                end
                for (int i = 0; i < NL; i++) begin
                    if (bus.lane_ray_wr_en[i] && bus.lane_ray_full_n[i]) begin
                        lane_in_q[i].push_back(bus.lane_ray_wr_data);
                        disp_lane_log.push_back(i);
                        disp_cyc_log.push_back(cycle);
                    end
                    if (bus.lane_result_rd_en[i] && bus.lane_result_empty_n[i]) begin
                        void'(lane_out_q[i].pop_front());
                        lane_rd_cnt[i]++;
                    end
                    if (!lane_res_block[i] && lane_in_q[i].size() > 0 && (!rnd || $urandom_range(0, 2) == 0))
                        lane_out_q[i].push_back(ray_result(lane_in_q[i].pop_front()));
                end
            end
            @(posedge aclk);
            #1;
            cycle++;
            drive_inputs();
        end
    end

    // Monitor: handshake legality every cycle, result order against the scoreboard queue.
    always @(negedge aclk) begin
        if (aresetn) begin
            logic viol;
            result_t exp_r;
            viol = (bus.ray_stream_rd_en && !bus.ray_stream_empty_n) ||
                   |(bus.lane_ray_wr_en & ~bus.lane_ray_full_n) ||
                   |(bus.lane_result_rd_en & ~bus.lane_result_empty_n) ||
                   (bus.result_stream_wr_en && !bus.result_stream_full_n) ||
                   !$onehot0(bus.lane_ray_wr_en) || !$onehot0(bus.lane_result_rd_en);
            check("handshake_protocol", viol, 1'b0);
            if (bus.result_stream_wr_en && bus.result_stream_full_n) begin
                if (exp_q.size() == 0) begin
                    check("extra_result", exp_q.size(), 1);
                end else begin
                    exp_r = exp_q.pop_front();
                    check("result_order", bus.result_stream_wr_data, exp_r);
                end
                n_results++;
                pop_cyc_log.push_back(cycle);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic wait_disp(int target, int budget);
        int t = 0;
        while (disp_lane_log.size() < target && t < budget) begin
            tick(1);
            t++;
        end
        check("dispatch_count", disp_lane_log.size(), target);
    endtask

    task automatic wait_pop(int target, int budget);
        int t = 0;
        while (pop_cyc_log.size() < target && t < budget) begin
            tick(1);
            t++;
        end
        check("result_count", pop_cyc_log.size(), target);
    endtask

    task automatic drain(int budget);
        int t = 0;
        while (exp_q.size() > 0 && t < budget) begin
            tick(1);
            t++;
        end
        tick(2);
        check("drain_outstanding", exp_q.size(), 0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int base, rbase, pbase, nb, l1;

        // Reset held for 100 cycles
        aresetn = 1'b0;
        tick(100);
        check("rst_ray_rd_en", bus.ray_stream_rd_en, 1'b0);
        check("rst_lane_wr_en", bus.lane_ray_wr_en, '0);
        check("rst_lane_rd_en", bus.lane_result_rd_en, '0);
        check("rst_result_wr_en", bus.result_stream_wr_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_stat_rays", stat_rays, 0);
        check("rst_stat_results", stat_results, 0);
        check("rst_stat_stalls", stat_stalls, 0);
        aresetn = 1'b1;
        tick(2);

        // Four rays, both lanes ready: 0,1,0,1 back to back, one cycle after the first read
        base  = disp_lane_log.size();
        rbase = read_cyc_log.size();
        for (int k = 0; k < 4; k++) send_ray();
        up_en = 1'b1;
        wait_disp(base + 4, 50);
        for (int k = 0; k < 4; k++) check("rr_lane", disp_lane_log[base+k], k % 2);
        for (int k = 1; k < 4; k++) check("rr_back_to_back", disp_cyc_log[base+k], disp_cyc_log[base] + k);
        check("first_write_latency", disp_cyc_log[base], read_cyc_log[rbase] + 1);
        drain(200);

        // Lane 1 finishes before lane 0: nothing leaves until the head lane delivers
        lane_res_block = 2'b01;
        nb = n_results;
        l1 = lane_rd_cnt[1];
        send_ray();
        send_ray();
        tick(15);
        check("head_blocks_results", n_results - nb, 0);
        check("nonhead_lane_waits", lane_rd_cnt[1] - l1, 0);
        check("lane1_result_pending", lane_out_q[1].size(), 1);
        lane_res_block = '0;
        drain(200);
        check("reorder_count", n_results - nb, 2);

        // Lane 0 full: three rays all go to lane 1 with no stall cycles
        lane_block = 2'b01;
        base = disp_lane_log.size();
        for (int k = 0; k < 3; k++) send_ray();
        wait_disp(base + 3, 50);
        for (int k = 0; k < 3; k++) check("lane0_full_route", disp_lane_log[base+k], 1);
        check("no_stalls", stat_stalls, 0);
        lane_block = '0;
        drain(200);

        // 17 rays with no results returned: 16 in flight, the 17th waits in the hold register
        lane_res_block = 2'b11;
        base = disp_lane_log.size();
        for (int k = 0; k < 17; k++) send_ray();
        tick(60);
        check("depth_limit_dispatched", disp_lane_log.size() - base, 16);
        check("full_queue_rd_en", bus.ray_stream_rd_en, 1'b0);
        check("ray17_in_hold", up_q.size(), 0);
        check("busy_when_full", busy, 1'b1);
        pbase = pop_cyc_log.size();
        lane_res_block = 2'b10;
        wait_pop(pbase + 1, 30);
        wait_disp(base + 17, 30);
        check("ray17_after_first_pop", disp_cyc_log[base+16], pop_cyc_log[pbase] + 1);
        lane_res_block = '0;
        drain(400);

        // Downstream full for a while with results waiting: nothing pushed, then resumes in order
        ds_block = 1'b1;
        nb = n_results;
        for (int k = 0; k < 6; k++) send_ray();
        tick(12);
        check("ds_full_no_push", n_results - nb, 0);
        check("ds_full_wr_en", bus.result_stream_wr_en, 1'b0);
        ds_block = 1'b0;
        drain(200);
        check("ds_resume_count", n_results - nb, 6);

        // Randomised traffic with random flow control on every port
        rnd = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 1) == 1) send_ray();
            if (k % 30 == 0) begin
                lane_block     = NL'($urandom_range(0, (1 << NL) - 1));
                lane_res_block = NL'($urandom_range(0, (1 << NL) - 1));
                ds_block       = ($urandom_range(0, 3) == 0);
            end
            tick(1);
        end
        lane_block     = '0;
        lane_res_block = '0;
        ds_block       = 1'b0;
        drain(4000);
        rnd = 1'b0;

        check("stat_rays_total", stat_rays, STATS ? rays_sent : 0);
        check("stat_results_total", stat_results, STATS ? rays_sent : 0);
        check("results_total", n_results, rays_sent);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

endmodule
